// File: rtl/note_slot_buffer_pkg.sv
// Shared types and defaults for the free-play note slot buffer.
// Optional undo support is enabled with the NOTE_UNDO_EN macro.
package free_play_pkg;

    localparam int NOTE_Y_W = 10;

    localparam logic [NOTE_Y_W-1:0] DEF_BLANK_Y     = 10'd50;
    localparam logic [23:0]         DEF_BLANK_COLOR = 24'hFFFFFF;

    typedef struct packed {
        logic [NOTE_Y_W-1:0] y;
        logic [23:0]         color;
    } note_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

endpackage

// File: rtl/note_slot_buffer_if.sv
// Note capture bus between key/colour selection and the staff renderer.
// The undo_in signal exists only when NOTE_UNDO_EN is defined.
interface note_slot_buffer_if #(
    parameter int NUM_SLOTS = 8,
    parameter int Y_W       = 10
);
    localparam int CW = $clog2(NUM_SLOTS + 1);

    logic                     clear_in;
    logic                     note_vld_in;
    logic [Y_W-1:0]           note_y_in;
    logic [23:0]              note_color_in;
`ifdef NOTE_UNDO_EN
    logic                     undo_in;
`endif
    logic [NUM_SLOTS*Y_W-1:0] note_y_out;
    logic [NUM_SLOTS*24-1:0]  note_color_out;
    logic [10:0]              cursor_x;
    logic [CW-1:0]            count_out;
    logic                     full_out;

    modport master (
        output clear_in, note_vld_in, note_y_in, note_color_in,
`ifdef NOTE_UNDO_EN
        output undo_in,
`endif
        input  note_y_out, note_color_out, cursor_x, count_out, full_out
    );

    modport slave (
        input  clear_in, note_vld_in, note_y_in, note_color_in,
`ifdef NOTE_UNDO_EN
        input  undo_in,
`endif
        output note_y_out, note_color_out, cursor_x, count_out, full_out
    );

endinterface

// File: rtl/note_slot_buffer_staff_cursor_gen.sv
// Registered cursor x: steps by CURSOR_STEP per note, reloads on clear/restart.
// No multiplier; the position tracks the next note count incrementally.
module staff_cursor_gen #(
    parameter logic [10:0] CURSOR_X0   = 11'd240,
    parameter logic [10:0] CURSOR_STEP = 11'd125
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        reload0,
    input  logic        reload1,
    input  logic        inc,
    input  logic        dec,
    output logic [10:0] cursor_x
);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cursor_x <= CURSOR_X0;
        end else if (reload0) begin
            cursor_x <= CURSOR_X0;
        end else if (reload1) begin
            cursor_x <= CURSOR_X0 + CURSOR_STEP;
        end else if (inc) begin
            cursor_x <= cursor_x + CURSOR_STEP;
        end else if (dec) begin
            cursor_x <= cursor_x - CURSOR_STEP;
        end
    end

endmodule

// File: rtl/note_slot_buffer.sv
// Free-play note slot buffer with restart or scroll policy when full.
// Define NOTE_UNDO_EN to add the undo_in pulse (remove newest note).
module note_slot_buffer
    import free_play_pkg::*;
#(
    parameter int              NUM_SLOTS   = 8,
    parameter int              Y_W         = NOTE_Y_W,
    parameter logic [Y_W-1:0]  BLANK_Y     = DEF_BLANK_Y,
    parameter logic [23:0]     BLANK_COLOR = DEF_BLANK_COLOR,
    parameter logic [10:0]     CURSOR_X0   = 11'd240,
    parameter logic [10:0]     CURSOR_STEP = 11'd125,
    parameter bit              SCROLL_MODE = 1'b0
) (
    input logic               clk_in,
    input logic               rst_n_in,
    note_slot_buffer_if.slave bus
);

    localparam int            CW    = $clog2(NUM_SLOTS + 1);
    localparam int            IW    = $clog2(NUM_SLOTS);
    localparam logic [CW-1:0] N_CNT = CW'(NUM_SLOTS);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [23:0]    color;
    } slot_t;

    slot_t         slots [NUM_SLOTS];
    slot_t         blank;
    slot_t         new_note;
    logic [CW-1:0] count;
    slot_state_e   state;
    logic          do_clear;
    logic          do_note;
    logic          do_undo;
    logic          restart;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] undo_idx;
    logic [10:0]   cursor;

    assign blank    = '{y: BLANK_Y, color: BLANK_COLOR};
    assign new_note = '{y: bus.note_y_in, color: bus.note_color_in};

    assign do_clear = bus.clear_in;
    assign do_note  = bus.note_vld_in && !bus.clear_in;
`ifdef NOTE_UNDO_EN
    assign do_undo  = bus.undo_in && !bus.clear_in
                      && !bus.note_vld_in && (state != EMPTY);
`else
    assign do_undo  = 1'b0;
`endif
    assign restart  = do_note && (state == FULL) && !SCROLL_MODE;

    // Only meaningful below FULL, where count fits the slot index.
    assign wr_idx   = count[IW-1:0];
    assign undo_idx = IW'(count - ONE);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || do_clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= blank;
            count <= '0;
            state <= EMPTY;
        end else if (do_note) begin
            if (state != FULL) begin
                slots[wr_idx] <= new_note;
                count <= count + ONE;
                state <= (count == N_CNT - ONE) ? FULL : FILL;
            end else if (SCROLL_MODE) begin
                for (int i = 0; i < NUM_SLOTS - 1; i++)
                    slots[i] <= slots[i+1];
                slots[NUM_SLOTS-1] <= new_note;
            end else begin
                for (int i = 1; i < NUM_SLOTS; i++) slots[i] <= blank;
                slots[0] <= new_note;
                count <= ONE;
                state <= FILL;
            end
        end else if (do_undo) begin
            slots[undo_idx] <= blank;
            count <= count - ONE;
            state <= (count == ONE) ? EMPTY : FILL;
        end
    end

    staff_cursor_gen #(
        .CURSOR_X0   (CURSOR_X0),
        .CURSOR_STEP (CURSOR_STEP)
    ) u_cursor (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .reload0  (do_clear),
        .reload1  (restart),
        .inc      (do_note && (state != FULL)),
        .dec      (do_undo),
        .cursor_x (cursor)
    );

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
        assign bus.note_y_out[g*Y_W +: Y_W]   = slots[g].y;
        assign bus.note_color_out[g*24 +: 24] = slots[g].color;
    end

    assign bus.cursor_x  = cursor;
    assign bus.count_out = count;
    assign bus.full_out  = (state == FULL);

endmodule

// File: tb/tb_note_slot_buffer.sv
// Directed bench: restart-mode and scroll-mode buffers driven in lockstep.
// Undo steps are exercised when NOTE_UNDO_EN is defined.
module tb_note_slot_buffer;

    logic clk_in = 1'b0;
    logic rst_n_in;

    always #5 clk_in = ~clk_in;

    note_slot_buffer_if #(.NUM_SLOTS(8), .Y_W(10)) bus_r ();
    note_slot_buffer_if #(.NUM_SLOTS(8), .Y_W(10)) bus_s ();

    note_slot_buffer #(.SCROLL_MODE(1'b0)) dut_r (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus_r.slave)
    );

    note_slot_buffer #(.SCROLL_MODE(1'b1)) dut_s (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus_s.slave)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [79:0]  BLANK_YB = {8{10'd50}};
    localparam logic [191:0] BLANK_CB = {8{24'hFFFFFF}};

    logic [79:0]  ey;
    logic [191:0] ec;
    logic [79:0]  ey_s;
    logic [191:0] ec_s;
    logic [9:0]   ny;
    logic [23:0]  nc;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input bit scroll,
                           input logic [79:0] xy, input logic [191:0] xc,
                           input int cnt, input int cur, input bit full);
        logic [79:0]  oy;
        logic [191:0] oc;
        logic [10:0]  ox;
        logic [3:0]   on;
        logic         of;
        oy = scroll ? bus_s.note_y_out     : bus_r.note_y_out;
        oc = scroll ? bus_s.note_color_out : bus_r.note_color_out;
        ox = scroll ? bus_s.cursor_x       : bus_r.cursor_x;
        on = scroll ? bus_s.count_out      : bus_r.count_out;
        of = scroll ? bus_s.full_out       : bus_r.full_out;
        chk({tag, ".y"},     256'(oy), 256'(xy));
        chk({tag, ".color"}, 256'(oc), 256'(xc));
        chk({tag, ".cursor"}, 256'(ox), 256'(cur));
        chk({tag, ".count"}, 256'(on), 256'(cnt));
        chk({tag, ".full"},  256'(of), 256'(full));
    endtask

    task automatic drive(input bit clr, input bit vld,
                         input logic [9:0] y, input logic [23:0] c);
        bus_r.clear_in      = clr;
        bus_s.clear_in      = clr;
        bus_r.note_vld_in   = vld;
        bus_s.note_vld_in   = vld;
        bus_r.note_y_in     = y;
        bus_s.note_y_in     = y;
        bus_r.note_color_in = c;
        bus_s.note_color_in = c;
    endtask

`ifdef NOTE_UNDO_EN
    task automatic drive_undo(input bit u);
        bus_r.undo_in = u;
        bus_s.undo_in = u;
    endtask
`endif

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 10'd0, 24'd0);
`ifdef NOTE_UNDO_EN
        drive_undo(1'b0);
`endif
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk_dut("reset_r", 1'b0, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        chk_dut("reset_s", 1'b1, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        rst_n_in = 1'b1;

        // Eight back-to-back notes fill every slot in order.
        ey = BLANK_YB;
        ec = BLANK_CB;
        for (int i = 0; i < 8; i++) begin
            ny = 10'(485 - 25 * i);
            nc = 24'hA00000 + 24'(i);
            drive(1'b0, 1'b1, ny, nc);
            tick();
            ey[i*10 +: 10] = ny;
            ec[i*24 +: 24] = nc;
            chk_dut($sformatf("fill%0d_r", i), 1'b0, ey, ec,
                    i + 1, 240 + 125 * (i + 1), i == 7);
            chk_dut($sformatf("fill%0d_s", i), 1'b1, ey, ec,
                    i + 1, 240 + 125 * (i + 1), i == 7);
        end

        // Ninth note: restart vs scroll.
        drive(1'b0, 1'b1, 10'd260, 24'h00ABCD);
        tick();
        ey_s = {10'd260, ey[79:10]};
        ec_s = {24'h00ABCD, ec[191:24]};
        chk_dut("restart", 1'b0, {BLANK_YB[79:10], 10'd260},
                {BLANK_CB[191:24], 24'h00ABCD}, 1, 365, 1'b0);
        chk_dut("scroll", 1'b1, ey_s, ec_s, 8, 1240, 1'b1);

        drive(1'b0, 1'b0, 10'd999, 24'h123456);
        tick();
        chk_dut("idle_r", 1'b0, {BLANK_YB[79:10], 10'd260},
                {BLANK_CB[191:24], 24'h00ABCD}, 1, 365, 1'b0);
        chk_dut("idle_s", 1'b1, ey_s, ec_s, 8, 1240, 1'b1);

        drive(1'b1, 1'b0, 10'd0, 24'd0);
        tick();
        chk_dut("clear_r", 1'b0, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        chk_dut("clear_s", 1'b1, BLANK_YB, BLANK_CB, 0, 240, 1'b0);

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 10'(400 - 10 * i), 24'h0000F0 + 24'(i));
            tick();
        end
        chk("five_count", 256'(bus_r.count_out), 256'(5));
        chk("five_cursor", 256'(bus_r.cursor_x), 256'(865));

        // Clear outranks a simultaneous note.
        drive(1'b1, 1'b1, 10'd123, 24'h654321);
        tick();
        chk_dut("clrvld_r", 1'b0, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        chk_dut("clrvld_s", 1'b1, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        drive(1'b0, 1'b0, 10'd0, 24'd0);
        tick();
        chk_dut("after_clr", 1'b0, BLANK_YB, BLANK_CB, 0, 240, 1'b0);

`ifdef NOTE_UNDO_EN
        ey = BLANK_YB;
        ec = BLANK_CB;
        for (int i = 0; i < 3; i++) begin
            ny = 10'(300 - 10 * i);
            nc = 24'h0B0000 + 24'(i);
            drive(1'b0, 1'b1, ny, nc);
            tick();
            ey[i*10 +: 10] = ny;
            ec[i*24 +: 24] = nc;
        end
        drive(1'b0, 1'b0, 10'd0, 24'd0);
        drive_undo(1'b1);
        tick();
        ey[20 +: 10] = 10'd50;
        ec[48 +: 24] = 24'hFFFFFF;
        chk_dut("undo1_r", 1'b0, ey, ec, 2, 490, 1'b0);
        chk_dut("undo1_s", 1'b1, ey, ec, 2, 490, 1'b0);

        // Note outranks undo in the same cycle.
        drive(1'b0, 1'b1, 10'd111, 24'h0C0C0C);
        tick();
        ey[20 +: 10] = 10'd111;
        ec[48 +: 24] = 24'h0C0C0C;
        chk_dut("vld_undo", 1'b0, ey, ec, 3, 615, 1'b0);

        drive(1'b0, 1'b0, 10'd0, 24'd0);
        repeat (3) tick();
        chk_dut("undo_all", 1'b0, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        repeat (3) tick();
        chk_dut("undo_empty_r", 1'b0, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        chk_dut("undo_empty_s", 1'b1, BLANK_YB, BLANK_CB, 0, 240, 1'b0);
        drive_undo(1'b0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
